// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// ----------------
// Writeback trace recorder. While capturing, every enabled writeback
// {wb_a, wb_d, pc_in} is pushed into an in-order FIFO. A dump request stops
// capture, and the stored events are streamed out over a valid/ready port.
//
// Optional feature macro: WB_TRACE_X0_FILTER_EN
//   defined   -> writebacks to x0 are neither stored nor counted as overflow
//   undefined -> x0 writebacks are recorded like any other event
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low; clears all state
//   wb_e      in   writeback valid this cycle
//   wb_a      in   destination register index [4:0]
//   wb_d      in   writeback data [31:0]
//   pc_in     in   PC of the retiring instruction [31:0]
//   dump      in   drain request, level-sensitive
//   tr_valid  out  trace beat available
//   tr_ready  in   consumer accepts beat
//   tr_data   out  {wb_a, wb_d, pc_in} of the FIFO head [68:0]
//   count     out  occupied entries, 0..DEPTH [CW-1:0]
//   overflow  out  sticky: at least one event dropped on a full FIFO
//   done      out  drain complete
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_e,
  input  logic [4:0]    wb_a,
  input  logic [31:0]   wb_d,
  input  logic [31:0]   pc_in,
  input  logic          dump,
  output logic          tr_valid,
  input  logic          tr_ready,
  output logic [68:0]   tr_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] CAPTURE = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] wr_ptr_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic          overflow_reg;
  logic [68:0]   mem [DEPTH];

  logic          rec_ok;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_now;

`ifdef WB_TRACE_X0_FILTER_EN
  assign rec_ok = (wb_a != 5'd0);
`else
  assign rec_ok = 1'b1;
`endif

  // Pointers carry one extra bit so that wr - rd distinguishes full from
  // empty; the low AW bits address the storage and wrap modulo DEPTH.
  assign count_now = wr_ptr_reg - rd_ptr_reg;
  assign full      = (count_now == CW'(DEPTH));
  assign empty     = (count_now == '0);

  // Push and pop live in different states, so they never coincide.
  assign push = (state_reg == CAPTURE) && wb_e && rec_ok && !full;
  assign pop  = (state_reg == DRAIN) && !empty && tr_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {wb_a, wb_d, pc_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= CAPTURE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + CW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + CW'(1);
      end
      case (state_reg)
        CAPTURE: begin
          // Oldest entries are retained; the new event is dropped.
          if (wb_e && rec_ok && full) begin
            overflow_reg <= 1'b1;
          end
          if (dump) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish when already empty or when this pop takes the last entry.
          if (empty || (pop && count_now == CW'(1))) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!dump) begin
            state_reg    <= CAPTURE;
            overflow_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= CAPTURE;
        end
      endcase
    end
  end

  assign tr_valid = (state_reg == DRAIN) && !empty;
  // Gated so the port reads zero whenever no beat is offered (incl. reset).
  assign tr_data  = tr_valid ? mem[rd_ptr_reg[AW-1:0]] : 69'd0;
  assign count    = count_now;
  assign overflow = overflow_reg;
  assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wb_e = 1'b0;
  logic [4:0]    wb_a = '0;
  logic [31:0]   wb_d = '0;
  logic [31:0]   pc_in = '0;
  logic          dump = 1'b0;
  logic          tr_valid;
  logic          tr_ready = 1'b0;
  logic [68:0]   tr_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;

  int tests = 0;
  int fails = 0;

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_e     (wb_e),
    .wb_a     (wb_a),
    .wb_d     (wb_d),
    .pc_in    (pc_in),
    .dump     (dump),
    .tr_valid (tr_valid),
    .tr_ready (tr_ready),
    .tr_data  (tr_data),
    .count    (count),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

`ifdef WB_TRACE_X0_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  // Drive one cycle's inputs, then advance to 1 time unit past the edge.
  task automatic cycle(input logic e, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic dmp, input logic rdy);
    wb_e = e; wb_a = a; wb_d = d; pc_in = pc; dump = dmp; tr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Drain everything and return to CAPTURE; no content checks.
  task automatic drain_all();
    int n = 0;
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    while (!done && n < DEPTH + 4) begin
      cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_all_timeout done=%0b required 1", done);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_e = 1'b1; wb_a = 5'd3; wb_d = 32'hAAAA5555; dump = 1'b0; tr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({tr_valid, tr_data, count, overflow, done} !== '0) begin
      fails++;
      $display("FAIL reset_held outputs=%h required 0", {tr_valid, tr_data, count, overflow, done});
    end
    wb_e = 1'b0;
    reset = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests++;
    if ({tr_valid, tr_data, count, overflow, done} !== '0) begin
      fails++;
      $display("FAIL reset_release outputs=%h required 0", {tr_valid, tr_data, count, overflow, done});
    end
    // A capture proves the FSM is in CAPTURE.
    cycle(1'b1, 5'd9, 32'h1, 32'h0, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(1)) begin
      fails++;
      $display("FAIL reset_capture count=%0d required 1", count);
    end
    drain_all();
  endtask

  task automatic test_basic_drain();
    logic [68:0] exp [3];
    int n;
    exp[0] = {5'd1, 32'hDEADBEEF, 32'd0};
    exp[1] = {5'd2, 32'h12345678, 32'd4};
    exp[2] = {5'd7, 32'h00000004, 32'd8};
    for (int i = 0; i < 3; i++)
      cycle(1'b1, exp[i][68:64], exp[i][63:32], exp[i][31:0], 1'b0, 1'b1);
    tests++;
    if (count !== CW'(3)) begin
      fails++;
      $display("FAIL basic_count count=%0d required 3", count);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tr_valid !== 1'b1 || tr_data !== exp[i]) begin
        fails++;
        $display("FAIL basic_beat%0d valid=%0b data=%h required 1 %h", i, tr_valid, tr_data, exp[i]);
      end
      // dump dropped mid-drain must not abort it
      cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    end
    n = 0;
    while (!done && n < 1) begin
      cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      n++;
    end
    tests++;
    if (done !== 1'b1 || tr_valid !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL basic_done done=%0b valid=%0b count=%0d required 1 0 0", done, tr_valid, count);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_return done=%0b required 0", done);
    end
  endtask

  task automatic test_x0_filter();
    cycle(1'b1, 5'd0, 32'h55, 32'h0, 1'b0, 1'b0);
    tests++;
    if (count !== (FILTER ? CW'(0) : CW'(1))) begin
      fails++;
      $display("FAIL x0_filter count=%0d required %0d", count, FILTER ? 0 : 1);
    end
    drain_all();
  endtask

  task automatic test_overflow();
    logic [31:0] dat [6];
    int beats = 0;
    for (int i = 0; i < 6; i++) begin
      dat[i] = $urandom;
      cycle(1'b1, 5'(i + 1), dat[i], 32'(4 * i), 1'b0, 1'b0);
    end
    tests++;
    if (count !== CW'(DEPTH) || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_state count=%0d ovf=%0b required %0d 1", count, overflow, DEPTH);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    for (int n = 0; n < DEPTH + 4 && !done; n++) begin
      if (tr_valid) begin
        tests++;
        if (beats >= 4 || tr_data !== {5'(beats + 1), dat[beats], 32'(4 * beats)}) begin
          fails++;
          $display("FAIL ovf_beat%0d data=%h required x%0d", beats, tr_data, beats + 1);
        end
        beats++;
      end
      cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    end
    tests++;
    if (beats != 4 || done !== 1'b1) begin
      fails++;
      $display("FAIL ovf_beats beats=%0d done=%0b required 4 1", beats, done);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (overflow !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear ovf=%0b done=%0b required 0 0", overflow, done);
    end
  endtask

  task automatic test_backpressure();
    logic [68:0] e0, e1;
    e0 = {5'd11, 32'hCAFEF00D, 32'h100};
    e1 = {5'd12, 32'h0BADC0DE, 32'h104};
    cycle(1'b1, e0[68:64], e0[63:32], e0[31:0], 1'b0, 1'b0);
    cycle(1'b1, e1[68:64], e1[63:32], e1[31:0], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tr_valid !== 1'b1 || tr_data !== e0 || count !== CW'(2)) begin
        fails++;
        $display("FAIL bp_hold%0d valid=%0b data=%h count=%0d required 1 %h 2", i, tr_valid, tr_data, count, e0);
      end
      cycle(1'b1, 5'd13, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tests++;
    if (count !== CW'(1) || tr_data !== e1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL bp_release count=%0d data=%h ovf=%0b required 1 %h 0", count, tr_data, overflow, e1);
    end
    drain_all();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(20 + i), $urandom, 32'(i * 4), 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    tests++;
    if (tr_valid !== 1'b0 || count !== '0 || tr_data !== '0) begin
      fails++;
      $display("FAIL rst_mid valid=%0b count=%0d data=%h required 0 0 0", tr_valid, count, tr_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (done !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL rst_after done=%0b count=%0d ovf=%0b required 0 0 0", done, count, overflow);
    end
    cycle(1'b1, 5'd5, 32'h77, 32'h0, 1'b0, 1'b0);
    tests++;
    if (count !== CW'(1)) begin
      fails++;
      $display("FAIL rst_capture count=%0d required 1", count);
    end
    drain_all();
  endtask

  // Random traffic against a queue-based reference model.
  task automatic test_random();
    logic [68:0] q [$];
    int mode = 0;            // 0 capturing, 1 draining, 2 finished
    bit  m_ovf = 1'b0;
    logic e, dmp, rdy;
    logic [4:0] a;
    logic [31:0] d, pc;
    logic [68:0] exp_data;
    bit exp_valid;
    for (int c = 0; c < 1500; c++) begin
      e   = ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      d   = $urandom;
      pc  = $urandom;
      dmp = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      if (mode == 0) begin
        if (e && !(FILTER && a == 5'd0)) begin
          if (q.size() == DEPTH) m_ovf = 1'b1;
          else q.push_back({a, d, pc});
        end
        if (dmp) mode = 1;
      end else if (mode == 1) begin
        if (q.size() == 0) mode = 2;
        else if (rdy) begin
          void'(q.pop_front());
          if (q.size() == 0) mode = 2;
        end
      end else if (!dmp) begin
        mode = 0;
        m_ovf = 1'b0;
      end
      cycle(e, a, d, pc, dmp, rdy);
      exp_valid = (mode == 1) && (q.size() > 0);
      exp_data  = exp_valid ? q[0] : 69'd0;
      tests++;
      if (count !== CW'(q.size()) || overflow !== m_ovf || done !== (mode == 2)
          || tr_valid !== exp_valid || tr_data !== exp_data) begin
        fails++;
        $display("FAIL rand_c%0d cnt=%0d ovf=%0b done=%0b v=%0b d=%h required %0d %0b %0b %0b %h",
                 c, count, overflow, done, tr_valid, tr_data,
                 q.size(), m_ovf, (mode == 2), exp_valid, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_x0_filter();
    test_overflow();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
